// File: rtl/inst_trace_streamer.sv
`default_nettype none
// ============================================================================
// Module   : inst_trace_streamer
// Purpose  : Buffered RV32I trace disassembler that streams each FIFO entry
//            as a fixed-width ASCII line, one byte per handshake.
//            Optional macro TRACE_PC_EN adds an 8-digit hex PC prefix.
// Revision : 1.0 - initial release
// ============================================================================
module inst_trace_streamer #(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_code,
    input  logic [31:0]            in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             out_char,
    output logic [$clog2(DEPTH):0] count,
    output logic                   line_active
);
    localparam int AW        = $clog2(DEPTH);
    localparam int CW        = AW + 1;
    localparam int FIELD_LEN = 19;
    localparam int FIELD_W   = FIELD_LEN * 8;
`ifdef TRACE_PC_EN
    localparam int PREFIX_LEN = 10;
    localparam int ENTRY_W    = 64;
`else
    localparam int PREFIX_LEN = 0;
    localparam int ENTRY_W    = 32;
`endif
    localparam int LINE_LEN = PREFIX_LEN + FIELD_LEN + 2;
    localparam int LINE_W   = LINE_LEN * 8;
    localparam logic [4:0] LAST_IDX = 5'(LINE_LEN - 1);
    localparam logic [FIELD_W-1:0] SPACES = {FIELD_LEN{8'h20}};

    localparam logic [2:0] K_R = 3'd0;
    localparam logic [2:0] K_I = 3'd1;
    localparam logic [2:0] K_S = 3'd2;
    localparam logic [2:0] K_B = 3'd3;
    localparam logic [2:0] K_J = 3'd4;
    localparam logic [2:0] K_U = 3'd5;

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_EMIT = 1'b1} state_t;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [55:0] reg_tok(input logic [4:0] r);
        logic [4:0] tens;
        logic [4:0] ones;
        tens = r / 5'd10;
        ones = r % 5'd10;
        return {32'h0, 8'h78, 8'h30 + {3'b000, tens}, 8'h30 + {3'b000, ones}};
    endfunction

    function automatic logic [55:0] imm_tok(input logic [23:0] v, input int nd);
        logic [55:0] t;
        t = '0;
        for (int i = 5; i >= 0; i--)
            if (i < nd) t = {t[47:0], hex_char(v[i*4 +: 4])};
        return {t[47:0], 8'h48};
    endfunction

    // Tokens are right-aligned; appending shifts earlier text toward the MSB.
    function automatic logic [FIELD_W-1:0] cat(input logic [FIELD_W-1:0] acc,
                                               input logic [55:0] tok, input int n);
        return (acc << (n * 8)) | {{(FIELD_W-56){1'b0}}, tok};
    endfunction

    function automatic logic [FIELD_W-1:0] render_field(input logic [31:0] c);
        logic [FIELD_W-1:0] acc;
        logic [39:0]        mn;
        logic [2:0]         kind;
        logic [2:0]         f3;
        logic [6:0]         f7;
        logic [55:0]        op [3];
        int                 olen [3];
        int                 nops;
        int                 len;
        int                 mlen;
        acc  = '0;
        mn   = '0;
        kind = K_R;
        len  = 0;
        mlen = 0;
        f3   = c[14:12];
        f7   = c[31:25];
        case (c[6:0])
            7'h33: begin
                kind = K_R;
                if (f7 == 7'h00) begin
                    case (f3)
                        3'd0: mn = "add";   3'd1: mn = "sll";
                        3'd2: mn = "slt";   3'd3: mn = "sltu";
                        3'd4: mn = "xor";   3'd5: mn = "srl";
                        3'd6: mn = "or";    default: mn = "and";
                    endcase
                end else if (f7 == 7'h20 && f3 == 3'd0) mn = "sub";
                else if (f7 == 7'h20 && f3 == 3'd5)     mn = "sra";
            end
            7'h13: begin
                kind = K_I;
                case (f3)
                    3'd0: mn = "addi";  3'd2: mn = "slti";
                    3'd3: mn = "sltiu"; 3'd4: mn = "xori";
                    3'd6: mn = "ori";   3'd7: mn = "andi";
                    3'd1: if (f7 == 7'h00) mn = "slli";
                    default: begin
                        if (f7 == 7'h00)      mn = "srli";
                        else if (f7 == 7'h20) mn = "srai";
                    end
                endcase
            end
            7'h03: begin
                kind = K_I;
                case (f3)
                    3'd0: mn = "lb";  3'd1: mn = "lh";  3'd2: mn = "lw";
                    3'd4: mn = "lbu"; 3'd5: mn = "lhu"; default: mn = '0;
                endcase
            end
            7'h23: begin
                kind = K_S;
                case (f3)
                    3'd0: mn = "sb"; 3'd1: mn = "sh"; 3'd2: mn = "sw";
                    default: mn = '0;
                endcase
            end
            7'h63: begin
                kind = K_B;
                case (f3)
                    3'd0: mn = "beq";  3'd1: mn = "bne";
                    3'd4: mn = "blt";  3'd5: mn = "bge";
                    3'd6: mn = "bltu"; 3'd7: mn = "bgeu";
                    default: mn = '0;
                endcase
            end
            7'h67: begin kind = K_I; if (f3 == 3'd0) mn = "jalr"; end
            7'h6F: begin kind = K_J; mn = "jal";   end
            7'h37: begin kind = K_U; mn = "lui";   end
            7'h17: begin kind = K_U; mn = "auipc"; end
            default: mn = '0;
        endcase
        for (int i = 0; i < 5; i++)
            if (mn[i*8 +: 8] != 8'h00) mlen++;

        op[0] = reg_tok(c[11:7]);  olen[0] = 3;
        op[1] = reg_tok(c[19:15]); olen[1] = 3;
        op[2] = reg_tok(c[24:20]); olen[2] = 3;
        nops  = 3;
        case (kind)
            K_I: begin op[2] = imm_tok({12'h0, c[31:20]}, 3); olen[2] = 4; end
            K_S: begin
                op[0] = reg_tok(c[19:15]); op[1] = reg_tok(c[24:20]);
                op[2] = imm_tok({12'h0, c[31:25], c[11:7]}, 3); olen[2] = 4;
            end
            K_B: begin
                op[0] = reg_tok(c[19:15]); op[1] = reg_tok(c[24:20]);
                op[2] = imm_tok({11'h0, c[31], c[7], c[30:25], c[11:8], 1'b0}, 4);
                olen[2] = 5;
            end
            K_J: begin
                op[1] = imm_tok({3'h0, c[31], c[19:12], c[20], c[30:21], 1'b0}, 6);
                olen[1] = 7; nops = 2;
            end
            K_U: begin op[1] = imm_tok({4'h0, c[31:12]}, 5); olen[1] = 6; nops = 2; end
            default: nops = 3;
        endcase

        // The all-zero word is a pipeline bubble; 0x13 is the canonical nop.
        if (c == 32'h0000_0000) begin
            acc = cat(acc, "nop D", 5);
            acc = cat(acc, "Stall", 5);
            len = 10;
        end else if (c == 32'h0000_0013) begin
            acc = cat(acc, "nop", 3);
            len = 3;
        end else if (mn == '0) begin
            acc = cat(acc, "illegal", 7);
            len = 7;
        end else begin
            acc = cat(acc, {16'h0, mn}, mlen);
            acc = cat(acc, 56'h20, 1);
            len = mlen + 1;
            for (int i = 0; i < 3; i++) begin
                if (i < nops) begin
                    if (i > 0) begin
                        acc = cat(acc, 56'h2C, 1);
                        len++;
                    end
                    acc = cat(acc, op[i], olen[i]);
                    len += olen[i];
                end
            end
        end
        return (acc << ((FIELD_LEN - len) * 8)) | (SPACES >> (len * 8));
    endfunction

`ifdef TRACE_PC_EN
    function automatic logic [LINE_W-1:0] make_line(input logic [ENTRY_W-1:0] e);
        logic [79:0] pfx;
        pfx = '0;
        for (int i = 7; i >= 0; i--) pfx = {pfx[71:0], hex_char(e[32 + i*4 +: 4])};
        pfx = {pfx[63:0], 8'h3A, 8'h20};
        return {pfx, render_field(e[31:0]), 8'h0D, 8'h0A};
    endfunction
    logic [ENTRY_W-1:0] in_entry;
    assign in_entry = {in_pc, in_code};
`else
    function automatic logic [LINE_W-1:0] make_line(input logic [ENTRY_W-1:0] e);
        return {render_field(e), 8'h0D, 8'h0A};
    endfunction
    logic [ENTRY_W-1:0] in_entry;
    logic               unused_pc;
    assign in_entry  = in_code;
    assign unused_pc = ^in_pc;
`endif

    state_t             state_q, state_d;
    logic [4:0]         idx_q, idx_d;
    logic [LINE_W-1:0]  line_q, line_d;
    logic [AW-1:0]      wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]      count_q, count_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];
    logic               push;
    logic               pop;

    assign in_ready    = (count_q != CW'(DEPTH));
    assign push        = in_valid && in_ready && !flush;
    assign out_valid   = (state_q == S_EMIT);
    assign line_active = (state_q == S_EMIT);
    assign out_char    = (state_q == S_EMIT) ? line_q[LINE_W-1 -: 8] : 8'h00;
    assign count       = count_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        line_d  = line_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        mem_d   = mem_q;
        pop     = 1'b0;
        if (flush) begin
            state_d = S_IDLE;
            idx_d   = '0;
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (state_q == S_IDLE) begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_EMIT;
                end
            end else if (out_ready) begin
                if (idx_q == LAST_IDX) begin
                    // Chain straight into the next line to avoid a bubble.
                    if (count_q != '0) pop = 1'b1;
                    else               state_d = S_IDLE;
                    idx_d = '0;
                end else begin
                    idx_d  = idx_q + 5'd1;
                    line_d = {line_q[LINE_W-9:0], 8'h00};
                end
            end
            if (pop) begin
                line_d = make_line(mem_q[rd_q]);
                rd_d   = rd_q + AW'(1);
            end
            if (push) begin
                mem_d[wr_q] = in_entry;
                wr_d        = wr_q + AW'(1);
            end
            count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            line_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            line_q  <= line_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_trace_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_trace_streamer
// Purpose  : Scoreboard bench for inst_trace_streamer (DEPTH = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_trace_streamer;
    localparam int DEPTH = 4;
`ifdef TRACE_PC_EN
    localparam bit PC_EN = 1'b1;
`else
    localparam bit PC_EN = 1'b0;
`endif
    localparam int LINE_LEN = PC_EN ? 31 : 21;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_code = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_char;
    logic [2:0]  count;
    logic        line_active;

    logic [7:0]  exp_q [$];
    int          n_checks = 0;
    int          n_fails = 0;
    bit          mon_en = 1'b1;

    inst_trace_streamer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char),
        .count(count), .line_active(line_active)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_line(input string txt, input logic [31:0] pc);
        string s;
        s = PC_EN ? $sformatf("%08X: %s", pc, txt) : txt;
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        for (int i = txt.len(); i < 19; i++) exp_q.push_back(8'h20);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic push(input logic [31:0] code, input logic [31:0] pc, input string txt,
                        input int max_wait, output bit ok);
        int n;
        n        = 0;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_code  = code;
        in_pc    = pc;
        @(negedge clk);
        while (!in_ready && n < max_wait) begin
            @(negedge clk);
            n++;
        end
        if (in_ready) begin
            ok = 1'b1;
            expect_line(txt, pc);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic push_ok(input logic [31:0] code, input logic [31:0] pc, input string txt);
        bit ok;
        push(code, pc, txt, 200, ok);
        check_eq({"accept ", txt}, {31'h0, ok}, 32'h1);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_q.size() != 0 || out_valid) && n < 2000);
        check_eq({tag, " drained"}, exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_handshakes(input int want);
        int hs;
        int n;
        hs = 0;
        n  = 0;
        while (hs < want && n < 200) begin
            @(negedge clk);
            if (out_valid && out_ready) hs++;
            n++;
        end
        check_eq("handshake count", hs, want);
        @(posedge clk);
        #1;
    endtask

    task automatic measure_run(output int run);
        int n;
        n   = 0;
        run = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 500; k++) begin
            if (!out_valid) break;
            run++;
            @(negedge clk);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && out_valid && out_ready) begin
            if (exp_q.size() == 0) check_eq("unexpected byte", exp_q.size(), 1);
            else                   check_eq("out_char", {24'h0, out_char}, {24'h0, exp_q.pop_front()});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        int          run;
        logic [7:0]  first_a;
        first_a = PC_EN ? 8'h30 : 8'h61;

        #12;
        check_eq("reset in_ready", {31'h0, in_ready}, 1);
        check_eq("reset out_valid", {31'h0, out_valid}, 0);
        check_eq("reset out_char", {24'h0, out_char}, 0);
        check_eq("reset count", {29'h0, count}, 0);
        check_eq("reset line_active", {31'h0, line_active}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single line: latency and 21 contiguous bytes.
        out_ready = 1'b1;
        push_ok(32'h0050_0093, 32'h0000_0010, "addi x01,x00,005H");
        @(negedge clk);
        check_eq("latency edge t valid", {31'h0, out_valid}, 0);
        check_eq("latency edge t count", {29'h0, count}, 1);
        @(negedge clk);
        check_eq("latency edge t+1 valid", {31'h0, out_valid}, 1);
        check_eq("first byte", {24'h0, out_char}, {24'h0, first_a});
        run = 1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!out_valid) break;
            run++;
        end
        check_eq("line1 run length", run, LINE_LEN);
        wait_drain("line1");

        // Two back-to-back lines with no bubble.
        push_ok(32'h4020_8133, 32'h0000_0014, "sub x02,x01,x02");
        push_ok(32'hFFFF_FFFF, 32'h0000_0018, "illegal");
        measure_run(run);
        check_eq("two-line run length", run, 2 * LINE_LEN);
        wait_drain("two-line");

        // Back-pressure: 5 accepted, 6th refused, held byte stable.
        out_ready = 1'b0;
        push_ok(32'h0050_0093, 32'h0000_0100, "addi x01,x00,005H");
        push_ok(32'h4020_8133, 32'h0000_0104, "sub x02,x01,x02");
        push_ok(32'h1234_52B7, 32'h0000_0108, "lui x05,12345H");
        push_ok(32'hFE20_9EE3, 32'h0000_010C, "bne x01,x02,1FFCH");
        push_ok(32'h0080_00EF, 32'h0000_0110, "jal x01,000008H");
        push(32'h0000_0013, 32'h0000_0114, "nop", 3, ok);
        check_eq("sixth refused", {31'h0, ok}, 0);
        check_eq("full in_ready", {31'h0, in_ready}, 0);
        check_eq("full count", {29'h0, count}, 4);
        check_eq("full out_valid", {31'h0, out_valid}, 1);
        check_eq("full out_char", {24'h0, out_char}, {24'h0, first_a});
        repeat (5) @(negedge clk);
        check_eq("held out_char", {24'h0, out_char}, {24'h0, first_a});
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain("full fifo");

        // Flush after 7 bytes, with a simultaneous offer that must be dropped.
        push_ok(32'h0050_0093, 32'h0000_0200, "addi x01,x00,005H");
        wait_handshakes(7);
        mon_en   = 1'b0;
        exp_q.delete();
        flush    = 1'b1;
        in_valid = 1'b1;
        in_code  = 32'h0050_0093;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        mon_en   = 1'b1;
        @(negedge clk);
        check_eq("flush out_valid", {31'h0, out_valid}, 0);
        check_eq("flush count", {29'h0, count}, 0);
        check_eq("flush line_active", {31'h0, line_active}, 0);
        @(posedge clk);
        #1;
        push_ok(32'h4020_8133, 32'h0000_0204, "sub x02,x01,x02");
        wait_drain("post flush");

        // Asynchronous reset mid-line.
        push_ok(32'h0050_0093, 32'h0000_0300, "addi x01,x00,005H");
        wait_handshakes(3);
        #2;
        mon_en = 1'b0;
        exp_q.delete();
        rst_n  = 1'b0;
        #1;
        check_eq("async rst out_valid", {31'h0, out_valid}, 0);
        check_eq("async rst line_active", {31'h0, line_active}, 0);
        check_eq("async rst out_char", {24'h0, out_char}, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        check_eq("post rst in_ready", {31'h0, in_ready}, 1);
        check_eq("post rst count", {29'h0, count}, 0);
        push_ok(32'h0000_0000, 32'h0000_0400, "nop DStall");
        wait_drain("nop DStall");

        // U / B / J immediate formatting.
        push_ok(32'h1234_52B7, 32'h0000_0500, "lui x05,12345H");
        push_ok(32'hFE20_9EE3, 32'h0000_0504, "bne x01,x02,1FFCH");
        push_ok(32'h0080_00EF, 32'h0000_0508, "jal x01,000008H");
        wait_drain("imm formats");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inst_trace_streamer.md
# inst_trace_streamer

- Buffered RV32I instruction-trace disassembler.
- Accepts retired instruction words, plus their PC, over a valid/ready handshake and queues them in a parametrised FIFO.
- Renders each word into a fixed-width ASCII line and streams it one byte per cycle over a second valid/ready port.
- Sits between the CPU commit point and the UART/console debug path; replaces per-cycle combinational decoding with a lossless, back-pressured trace.

## Interface
- `DEPTH`, default 8: FIFO entries; power of two, minimum 2.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `flush` input 1: synchronous clear of FIFO and current line.
- `in_valid` input 1: trace entry offered.
- `in_ready` output 1: entry accepted when `in_valid && in_ready`.
- `in_code` input 32: instruction word.
- `in_pc` input 32: instruction address; used only with `TRACE_PC_EN`.
- `out_valid` output 1: `out_char` valid.
- `out_ready` input 1: consumer takes the byte.
- `out_char` output 8: ASCII byte.
- `count` output log2(DEPTH)+1: FIFO occupancy, excluding the line being emitted.
- `line_active` output 1: a line is being emitted.

## Operation
- **FIFO:** `in_ready = (count != DEPTH)`. It is registered-derived only; a pop in the same cycle never raises it combinationally.
- **FSM states:**
  - IDLE: if `count != 0`, pop the head, render the line into the line register, reset the index to 0, go to EMIT.
  - EMIT: `out_valid = 1`, `out_char = line[index]`. On handshake, index increments.
  - EMIT, handshake on the last byte: if the FIFO is non-empty, pop and render the next line in the same edge and stay in EMIT (zero bubble); otherwise go to IDLE.
- **Line format:** 19-char mnemonic field, left-justified and space-padded, then 0x0D 0x0A. Line length is 21.
- **Registers:** `x` plus two decimal digits (`x00`..`x31`).
- **Immediates:** raw encoded bits in uppercase hex, suffix `H`, no sign handling.
  - I/S: 3 digits.
  - B: 4 digits, 13-bit offset.
  - J: 6 digits, 21-bit offset.
  - U: 5 digits, imm[31:12].
- **Operand order:**
  - R: `rd,rs1,rs2`.
  - I / load / jalr: `rd,rs1,imm`.
  - S and B: `rs1,rs2,imm`.
  - J / U: `rd,imm`.
  - Shift-immediates show imm[11:0], so `srai` includes bit 10.
- **Decoded set:**
  - R-type: add sub sll slt sltu xor srl sra or and.
  - I-ALU: addi slti sltiu xori ori andi slli srli srai.
  - Loads: lb lh lw lbu lhu.
  - Stores: sb sh sw.
  - Branches: beq bne blt bge bltu bgeu.
  - Jumps and upper-immediate: jal jalr lui auipc.
- **Special words:**
  - 0x00000000 → `nop DStall`.
  - 0x00000013 → `nop`.
  - Anything else undecoded → `illegal`.
- **Flush:** has priority over push, pop and emit. On the next edge the FIFO empties, the FSM goes to IDLE, and `out_valid` = 0. An `in_valid` coinciding with `flush` is dropped.

## Timing
- **Reset values:** `in_ready`=1, `out_valid`=0, `out_char`=8'h00, `count`=0, `line_active`=0, FSM=IDLE.
- **Reset mid-line:** outputs take reset values immediately; the partial line is never completed.
- **Latency:** entry accepted at edge t into an empty block → `out_valid` high after edge t+1 with byte 0.
- **Output stability:** `out_char` is stable while `out_valid && !out_ready`.
- **Throughput:** back-to-back lines stream with no idle cycle between the final 0x0A and the next byte 0.
- **Full FIFO with simultaneous pop:** `in_ready` rises the cycle after the pop.
- **Occupancy:** total buffered entries = DEPTH in the FIFO + 1 in the line register.

## Configuration
- **`TRACE_PC_EN` defined:**
  - FIFO stores `in_pc` with `in_code`.
  - Each line is prefixed by 8 uppercase hex PC digits, then `:` and a space.
  - Line length is 31.
- **`TRACE_PC_EN` undefined:**
  - `in_pc` is ignored and no PC storage is built.
  - Line length is 21.

## Test plan
- Push 0x00500093, `out_ready`=1 → `addi x01,x00,005H` + 2 spaces + 0D 0A. First byte appears 1 cycle after acceptance; 21 consecutive valid cycles. With `TRACE_PC_EN` and pc 0x00000010, the line starts `00000010: `.
- Push 0x40208133, then 0xFFFFFFFF → `sub x02,x01,x02`, then `illegal`. The 42 bytes are contiguous with no bubble.
- DEPTH=4, `out_ready`=0, offer 6 entries → 5 accepted, `in_ready`=0, `count`=4, `out_char`='a' held stable.
- Emit 7 bytes of a line, assert `flush` for 1 cycle → `out_valid`=0 and `count`=0 next cycle. The next push emits a fresh line from byte 0.
- Deassert `rst_n` asynchronously mid-line → `out_valid`/`line_active` drop before the next edge. After release, push 0x00000000 → `nop DStall` + 9 spaces + 0D 0A.
- Push 0x123452B7, 0xFE209EE3, 0x008000EF → `lui x05,12345H`, `bne x01,x02,1FFCH`, `jal x01,000008H`.
